// File: rtl/scr1_tcm_loader_if.sv
// Boot-loader bundle: byte stream in, TCM port A/B out, status back.
// master = the loader, slave = the channel/memory side.
interface scr1_tcm_loader_if #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 32'h00010000,
  parameter int SCR1_NBYTES = SCR1_WIDTH/8
);
  localparam int AW = $clog2(SCR1_SIZE);

  logic                   start;
  logic [AW-3:0]          base_addr;
  logic [AW-2:0]          word_count;
  logic                   s_valid;
  logic [7:0]             s_data;
  logic                   s_ready;
  logic                   mem_renb;
  logic                   mem_wenb;
  logic [SCR1_NBYTES-1:0] mem_webb;
  logic [AW-3:0]          mem_addrb;
  logic [SCR1_WIDTH-1:0]  mem_datab;
  logic                   mem_rena;
  logic [AW-3:0]          mem_addra;
  logic [SCR1_WIDTH-1:0]  mem_qa;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [SCR1_WIDTH-1:0]  checksum;

  modport master (
    input  start, base_addr, word_count, s_valid, s_data, mem_qa,
    output s_ready, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
           mem_rena, mem_addra, busy, done, err, checksum
  );
  modport slave (
    output start, base_addr, word_count, s_valid, s_data, mem_qa,
    input  s_ready, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
           mem_rena, mem_addra, busy, done, err, checksum
  );
endinterface

// File: rtl/scr1_tcm_loader.sv
// Packs a byte stream little-endian into TCM words via port B, then reads the
// region back via port A and compares modular checksums.
module scr1_tcm_loader #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 32'h00010000,
  parameter int SCR1_NBYTES = SCR1_WIDTH/8
) (
  input  logic               clk,
  input  logic               rst,
  scr1_tcm_loader_if.master  bus
);
  localparam int AW = $clog2(SCR1_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_DRAIN, S_DONE} state_t;

  state_t                       r_state, w_state_nxt;
  logic [AW-3:0]                r_base;
  logic [AW-2:0]                r_count, r_word_idx;
  logic [1:0]                   r_byte_idx;
  logic [SCR1_NBYTES-1:0][7:0]  r_word;
  logic [SCR1_WIDTH-1:0]        r_sum_wr, r_sum_rd, r_checksum;
  logic                         r_rd_vld, r_err;

  logic                         w_last;
  logic [AW-3:0]                w_addr;
  logic [SCR1_WIDTH-1:0]        w_sum_rd_nxt;

  assign w_last       = (r_word_idx == r_count - (AW-1)'(1));
  // Word address wraps naturally in AW-2 bits.
  assign w_addr       = r_base + r_word_idx[AW-3:0];
  assign w_sum_rd_nxt = r_sum_rd + (r_rd_vld ? bus.mem_qa : '0);

  assign bus.err      = r_err;
  assign bus.checksum = r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.s_ready   = 1'b0;
    bus.mem_renb  = 1'b0;
    bus.mem_wenb  = 1'b0;
    bus.mem_webb  = '0;
    bus.mem_addrb = '0;
    bus.mem_datab = '0;
    bus.mem_rena  = 1'b0;
    bus.mem_addra = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.start) w_state_nxt = (bus.word_count == '0) ? S_DONE : S_LOAD;
      S_LOAD: begin
        bus.s_ready = 1'b1;
        bus.busy    = 1'b1;
        if (bus.s_valid && r_byte_idx == 2'd3) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        bus.busy      = 1'b1;
        bus.mem_wenb  = 1'b1;
        bus.mem_webb  = '1;
        bus.mem_addrb = w_addr;
        bus.mem_datab = r_word;
        w_state_nxt   = w_last ? S_VERIFY : S_LOAD;
      end
      S_VERIFY: begin
        bus.busy      = 1'b1;
        bus.mem_rena  = 1'b1;
        bus.mem_addra = w_addr;
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_sum_wr   <= '0;
      r_sum_rd   <= '0;
      r_checksum <= '0;
      r_rd_vld   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Read data lags mem_rena by one cycle; DRAIN catches the last beat.
      r_rd_vld <= bus.mem_rena;
      if (r_rd_vld) r_sum_rd <= w_sum_rd_nxt;
      case (r_state)
        S_IDLE:
          if (bus.start) begin
            r_base     <= bus.base_addr;
            r_count    <= bus.word_count;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_sum_wr   <= '0;
            r_sum_rd   <= '0;
            r_err      <= 1'b0;
            r_checksum <= '0;
          end
        S_LOAD:
          if (bus.s_valid) begin
            r_word[r_byte_idx] <= bus.s_data;
            r_byte_idx         <= r_byte_idx + 2'd1;
          end
        S_WRITE: begin
          r_sum_wr   <= r_sum_wr + r_word;
          r_word_idx <= w_last ? '0 : r_word_idx + (AW-1)'(1);
        end
        S_VERIFY:
          r_word_idx <= r_word_idx + (AW-1)'(1);
        S_DRAIN: begin
          // Fold in the final read here so err is valid alongside done.
          r_err      <= (w_sum_rd_nxt != r_sum_wr);
          r_checksum <= r_sum_wr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scr1_tcm_loader.sv
// Randomized bench for scr1_tcm_loader: queue-based expectation model,
// behavioural TCM, per-cycle compare on the falling edge.
module tb_scr1_tcm_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scr1_tcm_loader_if #(.SCR1_WIDTH(32), .SCR1_SIZE(32'h00010000)) bus ();

  scr1_tcm_loader #(.SCR1_WIDTH(32), .SCR1_SIZE(32'h00010000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural TCM: write on port B, registered read on port A.
  logic [31:0] mem [0:16383];
  int rd_n    = 0;
  int flip_at = -1;
  int cyc     = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wenb) mem[bus.mem_addrb] <= bus.mem_datab;
    if (bus.mem_rena) begin
      bus.mem_qa <= (rd_n == flip_at) ? (mem[bus.mem_addra] ^ 32'h1) : mem[bus.mem_addra];
      rd_n <= rd_n + 1;
    end
  end

  // Expectation model
  logic [7:0]  stim [$];
  logic [13:0] wr_a [$];
  logic [31:0] wr_d [$];
  logic [13:0] rd_a [$];
  logic [31:0] ld_ck, held_ck;
  logic        ld_err, held_err;
  bit  active, exp_done, done_seen, contig;
  int  bytes_acc, writes_seen, done_cnt, start_cyc, done_cyc, lat_exp;

  always @(negedge clk) begin
    if (!rst) begin
      chk("renb_zero", bus.mem_renb, 0);
      chk("webb", bus.mem_webb, bus.mem_wenb ? 4'hF : 4'h0);
      if (bus.mem_wenb) begin
        writes_seen++;
        chk("wr_sready", bus.s_ready, 0);
        chk("wr_after_4_bytes", bytes_acc, 4*writes_seen);
        if (wr_a.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", bus.mem_addrb, wr_a.pop_front());
          chk("wr_data", bus.mem_datab, wr_d.pop_front());
        end
      end else begin
        chk("addrb_idle", bus.mem_addrb, 0);
        chk("datab_idle", bus.mem_datab, 0);
      end
      if (bus.mem_rena) begin
        if (wr_a.size() != 0) chk("rd_before_writes_done", 1, 0);
        if (rd_a.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", bus.mem_addra, rd_a.pop_front());
      end else chk("addra_idle", bus.mem_addra, 0);
      if (bus.s_valid && bus.s_ready) bytes_acc++;
      if (bus.done) begin
        done_cnt++; done_cyc = cyc; active = 0; done_seen = 1;
        chk("done_expected", exp_done, 1);
        exp_done = 0;
        chk("rd_all_issued", rd_a.size(), 0);
        held_err = ld_err; held_ck = ld_ck;
        if (contig) chk("done_latency", cyc - start_cyc, lat_exp);
      end
      chk("busy", bus.busy, active);
      chk("err", bus.err, held_err);
      chk("checksum", bus.checksum, held_ck);
    end
  end

  task automatic setup_load(input logic [13:0] base, input int n, input int gap, input int flip);
    logic [31:0] w, ck;
    ck = 0;
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    for (int i = 0; i < n; i++) begin
      w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
      wr_a.push_back(base + 14'(i)); wr_d.push_back(w);
      rd_a.push_back(base + 14'(i));
      ck += w;
    end
    ld_ck = ck; ld_err = (flip >= 0);
    flip_at = (flip >= 0) ? rd_n + flip : -1;
    bytes_acc = 0; writes_seen = 0; done_cnt = 0; done_seen = 0;
    contig = (gap == 0); lat_exp = (n == 0) ? 1 : 6*n + 2;
    exp_done = 1;
    bus.start = 1; bus.base_addr = base; bus.word_count = 15'(n); start_cyc = cyc;
    @(posedge clk); #1;
    held_err = 0; held_ck = 0; active = (n != 0);
  endtask

  task automatic feed(input int nbytes, input int gap);
    int idx = 0, guard = 0;
    bit hs;
    while (idx < nbytes && guard < 5000) begin
      bus.s_valid = ($urandom_range(99) >= gap);
      bus.s_data  = stim[idx];
      @(negedge clk); hs = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    if (idx < nbytes) chk("feed_timeout", idx, nbytes);
    bus.s_valid = 0; bus.s_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_seen && t < 2000) begin @(posedge clk); t++; end
    #1;
    if (!done_seen) chk("done_timeout", 0, 1);
    chk("writes_all_issued", wr_a.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk("single_done", done_cnt, 1);
  endtask

  task automatic run_load(input logic [13:0] base, input int n, input int gap, input int flip);
    setup_load(base, n, gap, flip);
    bus.start = 0;
    feed(4*n, gap);
    wait_done();
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    bus.start = 0; bus.base_addr = 0; bus.word_count = 0;
    bus.s_valid = 0; bus.s_data = 0;
    held_err = 0; held_ck = 0; ld_err = 0; ld_ck = 0;
    active = 0; exp_done = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_sready", bus.s_ready, 0);  chk("rst_wenb", bus.mem_wenb, 0);
    chk("rst_webb", bus.mem_webb, 0);   chk("rst_rena", bus.mem_rena, 0);
    chk("rst_busy", bus.busy, 0);       chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);         chk("rst_checksum", bus.checksum, 0);
    chk("rst_addrb", bus.mem_addrb, 0); chk("rst_datab", bus.mem_datab, 0);
    chk("rst_addra", bus.mem_addra, 0);
    rst = 0;
    @(posedge clk); #1;

    // Directed: continuous stream, literal pins
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(14'h10, 2, 0, -1);
    chk("lit_checksum", bus.checksum, 32'hCCAA8866);
    chk("lit_err", bus.err, 0);
    chk("lit_mem10", mem[16], 32'h44332211);
    chk("lit_mem11", mem[17], 32'h88776655);
    chk("lit_latency", done_cyc - start_cyc, 14);

    // Same data with stream gaps
    run_load(14'h10, 2, 40, -1);
    chk("gap_checksum", bus.checksum, 32'hCCAA8866);

    // Zero words; start held into DONE must be ignored
    setup_load(14'h55, 0, 0, -1);
    @(posedge clk); #1;
    bus.start = 0;
    wait_done();
    chk("zero_checksum", bus.checksum, 0);

    // Address wrap at top of 64 KiB
    rand_stim(2);
    run_load(14'h3FFF, 2, 0, -1);
    chk("wrap_top", mem[16383], {stim[3], stim[2], stim[1], stim[0]});
    chk("wrap_zero", mem[0], {stim[7], stim[6], stim[5], stim[4]});

    // Corrupted read-back
    rand_stim(3);
    run_load(14'h100, 3, 20, 1);
    chk("flip_err", bus.err, 1);
    repeat (5) @(posedge clk);
    #1 chk("flip_err_held", bus.err, 1);

    // Reset in LOAD after two bytes
    rand_stim(1);
    setup_load(14'h20, 1, 0, -1);
    bus.start = 0;
    feed(2, 0);
    rst = 1; #1;
    chk("mid_rst_busy", bus.busy, 0);    chk("mid_rst_sready", bus.s_ready, 0);
    chk("mid_rst_err", bus.err, 0);      chk("mid_rst_ck", bus.checksum, 0);
    chk("mid_rst_wenb", bus.mem_wenb, 0); chk("mid_rst_no_write", wr_a.size(), 1);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    active = 0; exp_done = 0; held_err = 0; held_ck = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Fresh load with a start pulsed while busy
    rand_stim(2);
    setup_load(14'h40, 2, 0, -1);
    bus.start = 0;
    @(posedge clk); #1;
    bus.start = 1; bus.base_addr = 14'h2222; bus.word_count = 15'd7;
    contig = 0;
    @(posedge clk); #1;
    bus.start = 0;
    feed(8, 0);
    wait_done();
    chk("post_rst_checksum", bus.checksum, ld_ck);

    // Random loads
    for (int k = 0; k < 6; k++) begin
      int n, gap, flip;
      n = $urandom_range(1, 6); gap = $urandom_range(0, 50);
      flip = ($urandom_range(3) == 0) ? $urandom_range(n-1) : -1;
      rand_stim(n);
      run_load(14'($urandom), n, gap, flip);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
